// File: rtl/iob_rr_arbiter_if.sv
// Request/grant bundle between bus masters and the round-robin arbiter.
// The master modport drives requests and acknowledges; the slave modport drives grants.
interface iob_rr_arbiter_if #(
  parameter int unsigned PORTS = 4
);
  localparam int unsigned IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORTS-1:0] request_i;
  logic [PORTS-1:0] acknowledge_i;
  logic [PORTS-1:0] grant_o;
  logic             grant_valid_o;
  logic [IDX_W-1:0] grant_encoded_o;

  modport master (
    output request_i,
    output acknowledge_i,
    input  grant_o,
    input  grant_valid_o,
    input  grant_encoded_o
  );

  modport slave (
    input  request_i,
    input  acknowledge_i,
    output grant_o,
    output grant_valid_o,
    output grant_encoded_o
  );
endinterface

// File: rtl/iob_rr_arbiter.sv
// Registered N-port arbiter: fixed or round-robin priority, selectable tie direction,
// optional grant locking until the owner drops its request or acknowledges.
module iob_rr_arbiter #(
  parameter int unsigned PORTS                = 4,
  parameter int unsigned ARB_TYPE_ROUND_ROBIN = 0,
  parameter string       ARB_BLOCK            = "NONE",
  parameter string       LSB_PRIORITY         = "LOW"
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  iob_rr_arbiter_if.slave   bus
);

  localparam int unsigned IDX_W     = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam bit          RR        = (ARB_TYPE_ROUND_ROBIN != 0);
  localparam bit          PRIO_LOW  = (LSB_PRIORITY == "LOW");
  localparam bit          BLOCK_REQ = (ARB_BLOCK == "REQUEST");
  localparam bit          BLOCK_ACK = (ARB_BLOCK == "ACKNOWLEDGE");

  logic [PORTS-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] enc_q, enc_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             owner_req;
  logic             owner_ack;
  logic             hold;
  logic [PORTS-1:0] mask;
  logic [PORTS-1:0] cand;
  logic [IDX_W-1:0] winner;

  // Index of the highest-priority set bit in the tie direction.
  function automatic logic [IDX_W-1:0] pick(input logic [PORTS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (PRIO_LOW) begin
      for (int i = int'(PORTS) - 1; i >= 0; i--) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(PORTS); i++) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    grant_d   = grant_q;
    valid_d   = valid_q;
    enc_d     = enc_q;
    ptr_d     = ptr_q;
    owner_req = 1'b0;
    owner_ack = 1'b0;
    mask      = '0;

    for (int i = 0; i < int'(PORTS); i++) begin
      if (enc_q == IDX_W'(i)) begin
        owner_req = bus.request_i[i];
        owner_ack = bus.acknowledge_i[i];
      end
      mask[i] = bus.request_i[i] &&
                (PRIO_LOW ? (IDX_W'(i) > ptr_q) : (IDX_W'(i) < ptr_q));
    end

    hold   = valid_q && ((BLOCK_REQ && owner_req) || (BLOCK_ACK && !owner_ack));
    cand   = (RR && (|mask)) ? mask : bus.request_i;
    winner = pick(cand);

    // Release edge doubles as the arbitration edge, so there is no idle bubble.
    if (!hold) begin
      if (|bus.request_i) begin
        grant_d = PORTS'(1) << winner;
        valid_d = 1'b1;
        enc_d   = winner;
        if (RR) ptr_d = winner;
      end else begin
        grant_d = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      grant_q <= '0;
      valid_q <= 1'b0;
      enc_q   <= '0;
      ptr_q   <= PRIO_LOW ? IDX_W'(PORTS - 1) : '0;
    end else begin
      grant_q <= grant_d;
      valid_q <= valid_d;
      enc_q   <= enc_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.grant_o         = grant_q;
  assign bus.grant_valid_o   = valid_q;
  assign bus.grant_encoded_o = enc_q;

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Directed bench for iob_rr_arbiter: several configurations side by side,
// table-driven vectors plus hand-written lock and reset sequences.
module tb_iob_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  iob_rr_arbiter_if #(.PORTS(4)) if_a ();
  iob_rr_arbiter_if #(.PORTS(4)) if_b ();
  iob_rr_arbiter_if #(.PORTS(4)) if_c ();
  iob_rr_arbiter_if #(.PORTS(4)) if_d ();
  iob_rr_arbiter_if #(.PORTS(4)) if_e ();
  iob_rr_arbiter_if #(.PORTS(1)) if_f ();

  iob_rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK("NONE"), .LSB_PRIORITY("LOW"))
    u_a (.clk_i(clk), .rst_n_i(rst_n), .bus(if_a));
  iob_rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK("NONE"), .LSB_PRIORITY("HIGH"))
    u_b (.clk_i(clk), .rst_n_i(rst_n), .bus(if_b));
  iob_rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK("NONE"), .LSB_PRIORITY("LOW"))
    u_c (.clk_i(clk), .rst_n_i(rst_n), .bus(if_c));
  iob_rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK("REQUEST"), .LSB_PRIORITY("LOW"))
    u_d (.clk_i(clk), .rst_n_i(rst_n), .bus(if_d));
  iob_rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK("ACKNOWLEDGE"), .LSB_PRIORITY("LOW"))
    u_e (.clk_i(clk), .rst_n_i(rst_n), .bus(if_e));
  iob_rr_arbiter #(.PORTS(1), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK("NONE"), .LSB_PRIORITY("LOW"))
    u_f (.clk_i(clk), .rst_n_i(rst_n), .bus(if_f));

  typedef struct {
    int unsigned dut;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        valid;
    logic [1:0]  enc;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add_vec(input int unsigned d, input logic [3:0] r, input logic [3:0] g,
                         input logic v, input logic [1:0] e, input string nm);
    vec_t t;
    t.dut = d; t.req = r; t.grant = g; t.valid = v; t.enc = e; t.name = nm;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_req(input int unsigned d, input logic [3:0] r);
    case (d)
      0: if_a.request_i = r;
      1: if_b.request_i = r;
      2: if_c.request_i = r;
      3: if_d.request_i = r;
      default: if_e.request_i = r;
    endcase
  endtask

  // Packed {grant, valid, enc} of one 4-port instance.
  function automatic logic [6:0] get_out(input int unsigned d);
    case (d)
      0: return {if_a.grant_o, if_a.grant_valid_o, if_a.grant_encoded_o};
      1: return {if_b.grant_o, if_b.grant_valid_o, if_b.grant_encoded_o};
      2: return {if_c.grant_o, if_c.grant_valid_o, if_c.grant_encoded_o};
      3: return {if_d.grant_o, if_d.grant_valid_o, if_d.grant_encoded_o};
      default: return {if_e.grant_o, if_e.grant_valid_o, if_e.grant_encoded_o};
    endcase
  endfunction

  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {grant,valid,enc}=%b, want %b", nm, act, exp);
    end
  endtask

  task automatic check4(input string nm, input int unsigned d, input logic [3:0] g,
                        input logic v, input logic [1:0] e);
    check(nm, get_out(d), {g, v, e});
  endtask

  initial begin
    rst_n = 1'b0;
    if_a.request_i = 4'b1111; if_a.acknowledge_i = '0;
    if_b.request_i = '0;      if_b.acknowledge_i = '0;
    if_c.request_i = '0;      if_c.acknowledge_i = '0;
    if_d.request_i = '0;      if_d.acknowledge_i = '0;
    if_e.request_i = '0;      if_e.acknowledge_i = '0;
    if_f.request_i = '0;      if_f.acknowledge_i = '0;

    // Fixed priority, LOW ties
    add_vec(0, 4'b0110, 4'b0010, 1'b1, 2'd1, "fix_lo_0110_a");
    add_vec(0, 4'b0110, 4'b0010, 1'b1, 2'd1, "fix_lo_0110_b");
    add_vec(0, 4'b1000, 4'b1000, 1'b1, 2'd3, "fix_lo_1000");
    add_vec(0, 4'b0000, 4'b0000, 1'b0, 2'd3, "fix_lo_idle_enc_hold");
    add_vec(0, 4'b1001, 4'b0001, 1'b1, 2'd0, "fix_lo_1001");
    // Fixed priority, HIGH ties
    add_vec(1, 4'b0110, 4'b0100, 1'b1, 2'd2, "fix_hi_0110_a");
    add_vec(1, 4'b0110, 4'b0100, 1'b1, 2'd2, "fix_hi_0110_b");
    add_vec(1, 4'b0001, 4'b0001, 1'b1, 2'd0, "fix_hi_0001");
    add_vec(1, 4'b1001, 4'b1000, 1'b1, 2'd3, "fix_hi_1001");
    // Round-robin rotation 0,1,3,0,1,3, then idle keeps the pointer at 3
    add_vec(2, 4'b1011, 4'b0001, 1'b1, 2'd0, "rr_rot_0");
    add_vec(2, 4'b1011, 4'b0010, 1'b1, 2'd1, "rr_rot_1");
    add_vec(2, 4'b1011, 4'b1000, 1'b1, 2'd3, "rr_rot_2");
    add_vec(2, 4'b1011, 4'b0001, 1'b1, 2'd0, "rr_rot_3");
    add_vec(2, 4'b1011, 4'b0010, 1'b1, 2'd1, "rr_rot_4");
    add_vec(2, 4'b1011, 4'b1000, 1'b1, 2'd3, "rr_rot_5");
    add_vec(2, 4'b0000, 4'b0000, 1'b0, 2'd3, "rr_idle");
    add_vec(2, 4'b1111, 4'b0001, 1'b1, 2'd0, "rr_after_idle");

    // Reset overrides requests
    tick();
    check4("reset_cyc0", 0, 4'b0000, 1'b0, 2'd0);
    tick();
    check4("reset_cyc1", 0, 4'b0000, 1'b0, 2'd0);
    rst_n = 1'b1;
    tick();
    check4("reset_first_grant", 0, 4'b0001, 1'b1, 2'd0);

    foreach (vecs[i]) begin
      apply_req(vecs[i].dut, vecs[i].req);
      tick();
      check4(vecs[i].name, vecs[i].dut, vecs[i].grant, vecs[i].valid, vecs[i].enc);
    end

    // Request change must not reach the outputs before the edge
    apply_req(0, 4'b0100);
    #2;
    check4("no_comb_path", 0, 4'b0001, 1'b1, 2'd0);
    tick();
    check4("comb_path_after_edge", 0, 4'b0100, 1'b1, 2'd2);

    // REQUEST lock: port 0 keeps the grant while requesting, then hand-off without gap
    apply_req(3, 4'b0011);
    for (int k = 0; k < 5; k++) begin
      tick();
      check4("req_lock_hold", 3, 4'b0001, 1'b1, 2'd0);
    end
    apply_req(3, 4'b0010);
    tick();
    check4("req_lock_handoff", 3, 4'b0010, 1'b1, 2'd1);
    apply_req(3, 4'b0000);
    tick();
    check4("req_lock_release_idle", 3, 4'b0000, 1'b0, 2'd1);

    // ACKNOWLEDGE lock on port 2
    apply_req(4, 4'b0100);
    tick();
    check4("ack_grant_p2", 4, 4'b0100, 1'b1, 2'd2);
    apply_req(4, 4'b0101);
    if_e.acknowledge_i = 4'b0001;
    tick();
    check4("ack_wrong_port", 4, 4'b0100, 1'b1, 2'd2);
    if_e.acknowledge_i = 4'b0000;
    tick();
    check4("ack_still_locked", 4, 4'b0100, 1'b1, 2'd2);
    apply_req(4, 4'b0001);
    tick();
    check4("ack_req_drop_no_release", 4, 4'b0100, 1'b1, 2'd2);
    if_e.acknowledge_i = 4'b0100;
    tick();
    check4("ack_release_next_owner", 4, 4'b0001, 1'b1, 2'd0);

    // Re-lock port 2 (pointer becomes 2) then reset mid-lock
    if_e.acknowledge_i = 4'b0001;
    apply_req(4, 4'b0100);
    tick();
    check4("ack_relock_p2", 4, 4'b0100, 1'b1, 2'd2);
    if_e.acknowledge_i = 4'b0000;
    apply_req(4, 4'b1111);
    tick();
    check4("ack_relock_held", 4, 4'b0100, 1'b1, 2'd2);
    rst_n = 1'b0;
    tick();
    check4("midreset_clear", 4, 4'b0000, 1'b0, 2'd0);
    rst_n = 1'b1;
    tick();
    check4("midreset_ptr_reset", 4, 4'b0001, 1'b1, 2'd0);

    // Single-port instance follows its request one cycle later
    if_f.request_i = 1'b1;
    tick();
    check("p1_grant", {3'b000, if_f.grant_o, if_f.grant_valid_o, 1'b0, if_f.grant_encoded_o},
          7'b0001100);
    if_f.request_i = 1'b0;
    tick();
    check("p1_idle", {3'b000, if_f.grant_o, if_f.grant_valid_o, 1'b0, if_f.grant_encoded_o},
          7'b0000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
